sfifo_byte_packer: RTL and testbench



---
 rtl/sfifo_byte_packer_pkg.sv | 13 +
 rtl/sfifo_byte_packer.sv | 127 ++++++++++++
 tb/tb_sfifo_byte_packer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_byte_packer_pkg.sv
// Shared definitions for the SFIFO byte packer and the WOU frame decoder:
// packer state encodings and the default pad byte.
package sfifo_byte_packer_pkg;

    typedef enum logic [1:0] {
        PACK_LO = 2'd0,
        PACK_HI = 2'd1,
        PACK_WR = 2'd2
    } pack_state_e;

    localparam logic [7:0] PACK_PAD_BYTE = 8'h00;

endpackage

// File: rtl/sfifo_byte_packer.sv
// Packs the WOU byte stream little-endian into SFIFO words with backpressure.
// Optional word counter on wcnt_o enabled by defining SFIFO_PACK_WCNT_EN.
module sfifo_byte_packer
    import sfifo_byte_packer_pkg::*;
#(
    parameter int                WOU_DW   = 8,
    parameter int                SFIFO_DW = 16,
    parameter logic [WOU_DW-1:0] PAD_BYTE = PACK_PAD_BYTE
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic [WOU_DW-1:0]   byte_i,
    input  logic                byte_vld_i,
    input  logic                byte_sof_i,
    input  logic                byte_eof_i,
    output logic                byte_rdy_o,
    output logic                sfifo_wr_o,
    output logic [SFIFO_DW-1:0] sfifo_do_o,
    input  logic                sfifo_full_i,
    output logic                odd_o,
    output logic                misalign_o,
    input  logic                misalign_clr_i,
    output logic [15:0]         wcnt_o
);

    pack_state_e state, next_state;
    logic        accept;
    logic        load_lo;
    logic        load_hi;
    logic        discard;

    assign accept = byte_vld_i & byte_rdy_o;

    // Every accepted byte is either a new low byte or completes the held word;
    // an eof on a low byte closes the word with the pad byte.
    always_comb begin
        next_state = state;
        byte_rdy_o = 1'b1;
        sfifo_wr_o = 1'b0;
        odd_o      = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        discard    = 1'b0;
        case (state)
            PACK_LO: begin
                if (accept) begin
                    load_lo    = 1'b1;
                    next_state = byte_eof_i ? PACK_WR : PACK_HI;
                end
            end
            PACK_HI: begin
                odd_o = 1'b1;
                if (accept) begin
                    if (byte_sof_i) begin
                        discard    = 1'b1;
                        load_lo    = 1'b1;
                        next_state = byte_eof_i ? PACK_WR : PACK_HI;
                    end else begin
                        load_hi    = 1'b1;
                        next_state = PACK_WR;
                    end
                end
            end
            PACK_WR: begin
                sfifo_wr_o = ~sfifo_full_i;
                byte_rdy_o = ~sfifo_full_i;
                if (sfifo_wr_o) begin
                    if (accept) begin
                        load_lo    = 1'b1;
                        next_state = byte_eof_i ? PACK_WR : PACK_HI;
                    end else begin
                        next_state = PACK_LO;
                    end
                end
            end
            default: next_state = PACK_LO;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= PACK_LO;
        end else begin
            state <= next_state;
        end
    end

    // The data register only moves on acceptance, so it is stable through WR.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sfifo_do_o <= '0;
        end else begin
            if (load_lo) begin
                sfifo_do_o[WOU_DW-1:0] <= byte_i;
                if (byte_eof_i) begin
                    sfifo_do_o[SFIFO_DW-1:WOU_DW] <= PAD_BYTE;
                end
            end
            if (load_hi) begin
                sfifo_do_o[SFIFO_DW-1:WOU_DW] <= byte_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            misalign_o <= 1'b0;
        end else if (discard) begin
            misalign_o <= 1'b1;
        end else if (misalign_clr_i) begin
            misalign_o <= 1'b0;
        end
    end

`ifdef SFIFO_PACK_WCNT_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wcnt_o <= '0;
        end else if (sfifo_wr_o) begin
            wcnt_o <= wcnt_o + 16'd1;
        end
    end
`else
    assign wcnt_o = '0;
`endif

endmodule

// File: tb/tb_sfifo_byte_packer.sv
// Directed self-checking bench for sfifo_byte_packer; the wcnt wrap check
// runs only when SFIFO_PACK_WCNT_EN is defined.
module tb_sfifo_byte_packer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic [7:0]  byte_i;
    logic        byte_vld_i;
    logic        byte_sof_i;
    logic        byte_eof_i;
    logic        byte_rdy_o;
    logic        sfifo_wr_o;
    logic [15:0] sfifo_do_o;
    logic        sfifo_full_i;
    logic        odd_o;
    logic        misalign_o;
    logic        misalign_clr_i;
    logic [15:0] wcnt_o;

    int          n_asserts = 0;
    int          n_fails   = 0;
    int          total_writes = 0;
    int          wcnt_base = 0;
    logic [15:0] writes[$];

    always #5 wb_clk_i = ~wb_clk_i;

    sfifo_byte_packer dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_n_i     (wb_rst_n_i),
        .byte_i         (byte_i),
        .byte_vld_i     (byte_vld_i),
        .byte_sof_i     (byte_sof_i),
        .byte_eof_i     (byte_eof_i),
        .byte_rdy_o     (byte_rdy_o),
        .sfifo_wr_o     (sfifo_wr_o),
        .sfifo_do_o     (sfifo_do_o),
        .sfifo_full_i   (sfifo_full_i),
        .odd_o          (odd_o),
        .misalign_o     (misalign_o),
        .misalign_clr_i (misalign_clr_i),
        .wcnt_o         (wcnt_o)
    );

    // Records every word the packer writes; inputs only change just after
    // the rising edge, so the falling edge sees the value the edge will use.
    always @(negedge wb_clk_i) begin
        if (sfifo_wr_o) begin
            writes.push_back(sfifo_do_o);
            total_writes++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [7:0] b,
                                 input logic sof, input logic eof);
        byte_vld_i = vld;
        byte_i     = b;
        byte_sof_i = sof;
        byte_eof_i = eof;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic expectWrite(input string tag, input logic [15:0] word);
        if (writes.size() == 0) begin
            checkOutput(tag, 32'hFFFF_FFFF, {16'h0, word});
        end else begin
            checkOutput(tag, {16'h0, writes.pop_front()}, {16'h0, word});
        end
    endtask

    function automatic logic [15:0] expWcnt();
`ifdef SFIFO_PACK_WCNT_EN
        return 16'(total_writes - wcnt_base);
`else
        return 16'h0;
`endif
    endfunction

    initial begin
        wb_rst_n_i     = 1'b0;
        byte_i         = 8'h00;
        byte_vld_i     = 1'b0;
        byte_sof_i     = 1'b0;
        byte_eof_i     = 1'b0;
        sfifo_full_i   = 1'b0;
        misalign_clr_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        checkOutput("rst_rdy", byte_rdy_o, 1);
        checkOutput("rst_wr", sfifo_wr_o, 0);
        checkOutput("rst_do", sfifo_do_o, 0);
        checkOutput("rst_odd", odd_o, 0);
        checkOutput("rst_mis", misalign_o, 0);
        checkOutput("rst_wcnt", wcnt_o, 0);
        wb_rst_n_i = 1'b1;

        // Even-length frame, back to back
        applyStimulus(1, 8'h11, 1, 0);
        checkOutput("t1_odd_a", odd_o, 1);
        checkOutput("t1_rdy_a", byte_rdy_o, 1);
        applyStimulus(1, 8'h22, 0, 0);
        checkOutput("t1_wr_a", sfifo_wr_o, 1);
        checkOutput("t1_do_a", sfifo_do_o, 16'h2211);
        checkOutput("t1_rdy_b", byte_rdy_o, 1);
        applyStimulus(1, 8'h33, 0, 0);
        checkOutput("t1_odd_b", odd_o, 1);
        applyStimulus(1, 8'h44, 0, 1);
        checkOutput("t1_wr_b", sfifo_wr_o, 1);
        checkOutput("t1_do_b", sfifo_do_o, 16'h4433);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("t1_wr_idle", sfifo_wr_o, 0);
        expectWrite("t1_w0", 16'h2211);
        expectWrite("t1_w1", 16'h4433);
        checkOutput("t1_extra", writes.size(), 0);
        checkOutput("t1_wcnt", wcnt_o, expWcnt());

        // Odd-length frame gets padded
        applyStimulus(1, 8'h11, 1, 0);
        applyStimulus(1, 8'h22, 0, 0);
        applyStimulus(1, 8'h33, 0, 1);
        checkOutput("t2_do", sfifo_do_o, 16'h0033);
        checkOutput("t2_wr", sfifo_wr_o, 1);
        checkOutput("t2_odd_wr", odd_o, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("t2_odd_end", odd_o, 0);
        expectWrite("t2_w0", 16'h2211);
        expectWrite("t2_w1", 16'h0033);
        checkOutput("t2_extra", writes.size(), 0);

        // Orphaned low byte discarded by a new sof; set wins over clear
        applyStimulus(1, 8'hAA, 1, 0);
        misalign_clr_i = 1'b1;
        applyStimulus(1, 8'hBB, 1, 0);
        misalign_clr_i = 1'b0;
        checkOutput("t3_mis_set", misalign_o, 1);
        checkOutput("t3_odd", odd_o, 1);
        checkOutput("t3_wr", sfifo_wr_o, 0);
        applyStimulus(1, 8'hCC, 0, 1);
        checkOutput("t3_do", sfifo_do_o, 16'hCCBB);
        checkOutput("t3_mis_hold", misalign_o, 1);
        applyStimulus(0, 8'h00, 0, 0);
        misalign_clr_i = 1'b1;
        applyStimulus(0, 8'h00, 0, 0);
        misalign_clr_i = 1'b0;
        checkOutput("t3_mis_clr", misalign_o, 0);
        expectWrite("t3_w0", 16'hCCBB);
        checkOutput("t3_extra", writes.size(), 0);

        // Backpressure: word held while full, released in a single write
        applyStimulus(1, 8'h11, 1, 0);
        sfifo_full_i = 1'b1;
        applyStimulus(1, 8'h22, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t4_rdy%0d", i), byte_rdy_o, 0);
            checkOutput($sformatf("t4_wr%0d", i), sfifo_wr_o, 0);
            checkOutput($sformatf("t4_do%0d", i), sfifo_do_o, 16'h2211);
            if (i < 4) applyStimulus(1, 8'h33, 0, 0);
        end
        sfifo_full_i = 1'b0;
        #1;
        checkOutput("t4_wr_rel", sfifo_wr_o, 1);
        checkOutput("t4_rdy_rel", byte_rdy_o, 1);
        applyStimulus(1, 8'h33, 0, 0);
        checkOutput("t4_odd", odd_o, 1);
        checkOutput("t4_do_lo", sfifo_do_o, 16'h2233);
        applyStimulus(1, 8'h44, 0, 1);
        checkOutput("t4_do_b", sfifo_do_o, 16'h4433);
        applyStimulus(0, 8'h00, 0, 0);
        expectWrite("t4_w0", 16'h2211);
        expectWrite("t4_w1", 16'h4433);
        checkOutput("t4_extra", writes.size(), 0);
        checkOutput("t4_wcnt", wcnt_o, expWcnt());

        // Asynchronous reset drops a held low byte
        applyStimulus(1, 8'h55, 1, 0);
        checkOutput("t5_odd_pre", odd_o, 1);
        byte_vld_i = 1'b0;
        #3;
        wb_rst_n_i = 1'b0;
        wcnt_base  = total_writes;
        #1;
        checkOutput("t5_odd_rst", odd_o, 0);
        checkOutput("t5_rdy_rst", byte_rdy_o, 1);
        checkOutput("t5_do_rst", sfifo_do_o, 0);
        checkOutput("t5_wcnt_rst", wcnt_o, 0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;
        applyStimulus(1, 8'h01, 1, 0);
        applyStimulus(1, 8'h02, 0, 1);
        checkOutput("t5_do", sfifo_do_o, 16'h0201);
        checkOutput("t5_wr", sfifo_wr_o, 1);
        applyStimulus(0, 8'h00, 0, 0);
        expectWrite("t5_w0", 16'h0201);
        checkOutput("t5_extra", writes.size(), 0);
        checkOutput("t5_wcnt", wcnt_o, expWcnt());

`ifdef SFIFO_PACK_WCNT_EN
        // One-byte frames write a word every cycle; run the counter past wrap
        begin
            int remaining;
            remaining = 65537 - (total_writes - wcnt_base);
            for (int i = 0; i < remaining; i++) begin
                applyStimulus(1, 8'(i), 1, 1);
            end
            applyStimulus(0, 8'h00, 0, 0);
            checkOutput("t6_wcnt_wrap", wcnt_o, 16'd1);
            checkOutput("t6_total", total_writes - wcnt_base, 65537);
            writes.delete();
        end
`else
        checkOutput("t6_wcnt_off", wcnt_o, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
